pcg_multi_stream: RTL and testbench
===================================

// Module: pcg_multi_stream
// PURPOSE
//  Parametrised multi-channel PCG (XSH-RR) pseudo-random generator. It replaces the fixed 16-bit/8-bit single-stream generator.
//  NUM_CH independent streams step in lock-step and share one ready/valid output handshake.
//  Each channel has its own state and its own odd increment, plus run-time seeding.
//  It feeds VGA dither/noise overlays and other demoscene effects needing per-channel randomness.
// PARAMETERS
//  STATE_W   16       LCG state width per channel; must be >= OUT_W + ROT_W
//  OUT_W     8        output word width per channel; power of two, >= 4
//  NUM_CH    2        number of channels, 1..8
//  MULT      16'h5851 LCG multiplier (STATE_W bits)
//  INC       16'h1405 base increment; channel c uses INC + 2*c (kept odd by forcing bit0=1)
// PORTS
//  clk        in   1               clock
//  rst_n      in   1               synchronous, active-low reset
//  en         in   1               request to advance all channels
//  out_ready  in   1               consumer accepts out_data
//  out_valid  out  1               out_data holds an unconsumed word set
//  out_data   out  NUM_CH*OUT_W    channel c at [c*OUT_W +: OUT_W]
//  seed_we    in   1               write seed_val into channel seed_ch state
//  seed_ch    in   3               target channel; values >= NUM_CH ignored
//  seed_val   in   STATE_W         new state value
//  inc_we     in   1               increment write strobe (used only with PCG_INC_LOAD_EN)
//  inc_val    in   STATE_W         new increment for seed_ch (bit0 forced to 1)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): every state=0; increments = INC+2*c; out_valid=0; out_data=0.
//  - Derived widths and shifts:
//    - ROT_W = clog2(OUT_W)
//    - XSH = (OUT_W+ROT_W)/2 (integer)
//    - SHIFT = STATE_W-OUT_W-ROT_W
//  - Permutation perm(s):
//    - x = (((s>>XSH)^s)>>SHIFT)[OUT_W-1:0]
//    - r = s[STATE_W-1 -: ROT_W]
//    - perm(s) = rotate-right(x, r); r=0 gives x unchanged, so no zero-fill.
//  - step = en & (~out_valid | out_ready). On step, per channel:
//    - out_data[c] <= perm(state[c]), computed on the pre-advance state
//    - state[c] <= state[c]*MULT + inc[c] mod 2^STATE_W
//    - out_valid <= 1
//  - Latency: a word set is visible the cycle after the step that produced it. At full throughput, one word set per cycle.
//  - No step while out_valid & ~out_ready: out_data, out_valid and all states hold (stall, no loss, no duplicates).
//  - out_valid & out_ready & ~en: out_valid <= 0; out_data holds its last value.
//  - seed_we: state[seed_ch] <= seed_val, taking priority over a same-cycle step for that channel only.
//    - The current out_data is unaffected.
//    - The next produced word for that channel is perm(seed_val).
//  - seed_ch >= NUM_CH: the write is dropped with no side effects.
//  - Reset mid-stall: the pending word is discarded and out_valid=0 on the next cycle.
//  - The multiply is full-width truncated; the RTL may use one shared mul per channel with no pipelining (single cycle).
// CONFIGURATION
//  PCG_INC_LOAD_EN defined:
//    - inc_we writes inc[seed_ch] <= inc_val | 1, taking effect from the next step.
//    - Simultaneous seed_we + inc_we are both applied.
//    - The same-cycle step uses the old increment.
//  PCG_INC_LOAD_EN undefined:
//    - Increments are constant INC+2*c.
//    - inc_we and inc_val are ignored (ports remain, unused).
// TESTING
//  1 Reset, en=1, out_ready=1, defaults:
//    - ch0 words 0x00, 0xA5, 0x02
//    - ch0 state after the 2nd step = 0x219A
//    - ch1 words 0x00, 0xA5
//  2 Stall: hold out_ready=0 for 5 cycles with en=1:
//    - out_data and out_valid are constant
//    - on release the sequence resumes with no word skipped or repeated vs scenario 1
//  3 Seed: seed_we=1, seed_ch=1, seed_val=0x1405 during streaming:
//    - the next ch1 word is 0xA5, followed by the ch1 sequence from that state
//    - ch0 is undisturbed
//  4 Invalid seed: seed_ch=7 with NUM_CH=2 -> both channel sequences are identical to the unseeded reference model.
//  5 en=0 while out_valid: one handshake clears out_valid; states are frozen; re-asserting en continues the sequence.
//  6 PCG_INC_LOAD_EN:
//    - inc_we with inc_val=0x0002 on ch0 -> increment 0x0003 is used from the next step
//    - the sequence matches the model; the build without the macro ignores the write

Source files
------------

// File: rtl/pcg_multi_stream.sv
// Multi-channel PCG (XSH-RR) generator: NUM_CH LCG streams stepping together behind one
// ready/valid output. Define PCG_INC_LOAD_EN to make per-channel increments run-time writable.
module pcg_multi_stream #(
   parameter int unsigned        STATE_W = 16,
   parameter int unsigned        OUT_W   = 8,
   parameter int unsigned        NUM_CH  = 2,
   parameter logic [STATE_W-1:0] MULT    = 16'h5851,
   parameter logic [STATE_W-1:0] INC     = 16'h1405
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en_i,
   input  logic                      out_ready_i,
   output logic                      out_valid_o,
   output logic [NUM_CH*OUT_W-1:0]   out_data_o,
   input  logic                      seed_we_i,
   input  logic [2:0]                seed_ch_i,
   input  logic [STATE_W-1:0]        seed_val_i,
   input  logic                      inc_we_i,
   input  logic [STATE_W-1:0]        inc_val_i
);

   localparam int unsigned ROT_W = $clog2(OUT_W);
   localparam int unsigned XSH   = (OUT_W + ROT_W) / 2;
   localparam int unsigned SHIFT = STATE_W - OUT_W - ROT_W;

   // XSH-RR output permutation; rotating a doubled word avoids a zero-fill special case at r=0.
   function automatic logic [OUT_W-1:0] perm(input logic [STATE_W-1:0] s);
      logic [STATE_W-1:0] mix;
      logic [ROT_W-1:0]   rot;
      logic [2*OUT_W-1:0] dbl;
      mix = ((s >> XSH) ^ s) >> SHIFT;
      rot = s[STATE_W-1 -: ROT_W];
      dbl = {mix[OUT_W-1:0], mix[OUT_W-1:0]} >> rot;
      return dbl[OUT_W-1:0];
   endfunction

   logic                    step;
   logic                    out_valid_q, out_valid_d;
   logic [NUM_CH*OUT_W-1:0] out_data_q, out_data_d;
   logic [NUM_CH*OUT_W-1:0] perm_all;

   assign step = en_i & (~out_valid_q | out_ready_i);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      localparam logic [STATE_W-1:0] IncBase = (INC + STATE_W'(2 * c)) | STATE_W'(1);

      logic [STATE_W-1:0] state_q, state_d;
      logic [STATE_W-1:0] inc_cur;
      logic               seed_hit;

      // Out-of-range channel numbers never match, so such writes fall away naturally.
      assign seed_hit = seed_we_i && (seed_ch_i == 3'(c));

`ifdef PCG_INC_LOAD_EN
      logic [STATE_W-1:0] inc_q;
      logic               inc_hit;

      assign inc_hit = inc_we_i && (seed_ch_i == 3'(c));

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            inc_q <= IncBase;
         end else if (inc_hit) begin
            inc_q <= inc_val_i | STATE_W'(1);
         end
      end

      assign inc_cur = inc_q;
`else
      assign inc_cur = IncBase;
`endif

      always_comb begin
         state_d = state_q;
         if (seed_hit) begin
            state_d = seed_val_i;
         end else if (step) begin
            state_d = state_q * MULT + inc_cur;
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            state_q <= '0;
         end else begin
            state_q <= state_d;
         end
      end

      assign perm_all[c*OUT_W +: OUT_W] = perm(state_q);
   end

`ifndef PCG_INC_LOAD_EN
   logic unused_inc;
   assign unused_inc = ^{inc_we_i, inc_val_i};
`endif

   always_comb begin
      out_valid_d = out_valid_q & ~out_ready_i;
      out_data_d  = out_data_q;
      if (step) begin
         out_valid_d = 1'b1;
         out_data_d  = perm_all;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_pcg_multi_stream.sv
// Bench for pcg_multi_stream: known-answer vector table, corner-case sequences and random
// traffic checked against an arithmetic reference model.
module tb_pcg_multi_stream;

   localparam int unsigned STATE_W = 16;
   localparam int unsigned OUT_W   = 8;
   localparam int unsigned NUM_CH  = 2;
   localparam int unsigned ROT_W   = 3;
   localparam int unsigned XSH     = 5;
   localparam int unsigned SHIFT   = 5;
   localparam int          MULT    = 'h5851;
   localparam int          INC     = 'h1405;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    en;
   logic                    out_ready;
   logic                    out_valid;
   logic [NUM_CH*OUT_W-1:0] out_data;
   logic                    seed_we;
   logic [2:0]              seed_ch;
   logic [STATE_W-1:0]      seed_val;
   logic                    inc_we;
   logic [STATE_W-1:0]      inc_val;

   int checks = 0;
   int errors = 0;

   int m_st   [NUM_CH];
   int m_inc  [NUM_CH];
   int m_word [NUM_CH];
   bit m_valid;

   always #5 clk = ~clk;

   pcg_multi_stream #(
      .STATE_W (STATE_W),
      .OUT_W   (OUT_W),
      .NUM_CH  (NUM_CH),
      .MULT    (16'h5851),
      .INC     (16'h1405)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en_i        (en),
      .out_ready_i (out_ready),
      .out_valid_o (out_valid),
      .out_data_o  (out_data),
      .seed_we_i   (seed_we),
      .seed_ch_i   (seed_ch),
      .seed_val_i  (seed_val),
      .inc_we_i    (inc_we),
      .inc_val_i   (inc_val)
   );

   function automatic int mperm(int s);
      int x;
      int r;
      x = (((s >> XSH) ^ s) >> SHIFT) % (1 << OUT_W);
      r = s >> (STATE_W - ROT_W);
      return ((x >> r) | (x << (OUT_W - r))) & ((1 << OUT_W) - 1);
   endfunction

   function automatic int mnext(int s, int inc);
      return int'((longint'(s) * longint'(MULT) + longint'(inc)) % (longint'(1) << STATE_W));
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_st[c]   = 0;
         m_inc[c]  = (INC + 2 * c) | 1;
         m_word[c] = 0;
      end
      m_valid = 1'b0;
   endtask

   // Drive one cycle, advance the model, then compare all outputs after the edge.
   task automatic cycle(input bit rst, input bit e, input bit r, input bit swe, input int sch,
                        input int sval, input bit iwe, input int ival);
      bit step;
      rst_n    = rst;
      en       = e;
      out_ready = r;
      seed_we  = swe;
      seed_ch  = 3'(sch);
      seed_val = 16'(sval);
      inc_we   = iwe;
      inc_val  = 16'(ival);
      if (!rst) begin
         model_reset();
      end else begin
         step = e && (!m_valid || r);
         if (step) begin
            for (int c = 0; c < NUM_CH; c++) begin
               m_word[c] = mperm(m_st[c]);
               m_st[c]   = mnext(m_st[c], m_inc[c]);
            end
            m_valid = 1'b1;
         end else if (m_valid && r) begin
            m_valid = 1'b0;
         end
         if (swe && sch < NUM_CH) m_st[sch] = sval;
`ifdef PCG_INC_LOAD_EN
         if (iwe && sch < NUM_CH) m_inc[sch] = ival | 1;
`endif
      end
      @(posedge clk);
      #1;
      check("model_valid", int'(out_valid), int'(m_valid));
      for (int c = 0; c < NUM_CH; c++) begin
         check($sformatf("model_data_ch%0d", c), int'(out_data[c*OUT_W +: OUT_W]), m_word[c]);
      end
   endtask

   task automatic run(input bit e, input bit r);
      cycle(1'b1, e, r, 1'b0, 0, 0, 1'b0, 0);
   endtask

   typedef struct {
      bit    rst;
      bit    en;
      bit    rdy;
      bit    valid;
      int    d0;
      int    d1;
      string name;
   } vec_t;

   vec_t vecs[7];
   int   hold0;
   int   hold1;

   initial begin
      rst_n = 1'b0; en = 1'b0; out_ready = 1'b0; seed_we = 1'b0; seed_ch = '0;
      seed_val = '0; inc_we = 1'b0; inc_val = '0;
      model_reset();

      vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 'h00, 'h00, "reset"};
      vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 'h00, 'h00, "word1"};
      vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 'hA5, 'hA5, "word2"};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 'h02, 'h96, "word3"};
      vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 'h02, 'h96, "hold1"};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 'h02, 'h96, "hold2"};
      vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 'h02, 'h96, "drain"};

      for (int i = 0; i < 7; i++) begin
         cycle(vecs[i].rst, vecs[i].en, vecs[i].rdy, 1'b0, 0, 0, 1'b0, 0);
         check({vecs[i].name, "_valid"}, int'(out_valid), int'(vecs[i].valid));
         check({vecs[i].name, "_ch0"}, int'(out_data[7:0]), vecs[i].d0);
         check({vecs[i].name, "_ch1"}, int'(out_data[15:8]), vecs[i].d1);
      end

      // Long stall: output pinned to the word pending before the stall.
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0);
      for (int i = 0; i < 3; i++) run(1'b1, 1'b1);
      hold0 = m_word[0];
      hold1 = m_word[1];
      for (int i = 0; i < 5; i++) begin
         run(1'b1, 1'b0);
         check("stall_valid", int'(out_valid), 1);
         check("stall_ch0", int'(out_data[7:0]), hold0);
         check("stall_ch1", int'(out_data[15:8]), hold1);
      end
      for (int i = 0; i < 4; i++) run(1'b1, 1'b1);

      // Seed ch1 mid-stream; the word after the seed cycle must be perm(0x1405).
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1, 'h1405, 1'b0, 0);
      run(1'b1, 1'b1);
      check("seed_ch1_word", int'(out_data[15:8]), 'hA5);
      for (int i = 0; i < 3; i++) run(1'b1, 1'b1);

      // Out-of-range seed channel is dropped.
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 7, 'hFFFF, 1'b0, 0);
      for (int i = 0; i < 4; i++) run(1'b1, 1'b1);

      // en low while valid: one handshake clears valid, data holds, states frozen.
      hold0 = m_word[0];
      run(1'b0, 1'b1);
      check("idle_valid", int'(out_valid), 0);
      check("idle_ch0_hold", int'(out_data[7:0]), hold0);
      run(1'b0, 1'b0);
      run(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) run(1'b1, 1'b1);

      // Increment write on ch0 (ignored unless the load feature is built in).
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0);
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b1, 'h0002);
      for (int i = 0; i < 5; i++) run(1'b1, 1'b1);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 'hFFFF)),
               ($urandom_range(0, 7) == 0), int'($urandom_range(0, 'hFFFF)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
